// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage external SRAM controller: FSM encoding and
// default mapping parameters.
package mem_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int unsigned BASE_ADDR_DEFAULT = 1024;
  localparam int unsigned SRAM_AW_DEFAULT   = 18;
  localparam int unsigned CNT_W             = 4;

endpackage

// File: rtl/mem_sram_ctrl_if.sv
// Pipeline-side load/store bus of the SRAM controller. The pipeline is the master; the
// controller is the slave and returns read data plus the ready/freeze flag.
interface mem_sram_ctrl_if;

  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/mem_wait_counter.sv
// Per-access wait counter: counts clocks since the last clear and flags the final cycle
// of a WAIT_CYCLES-long halfword access.
module mem_wait_counter
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_sram_ctrl.sv
// Sequences 32-bit MEM-stage loads/stores as two halfword accesses (low, then high) on a
// 16-bit asynchronous SRAM, freezing the pipeline through ready while busy.
module mem_sram_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int unsigned SRAM_AW     = SRAM_AW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  mem_sram_ctrl_if.slave     bus,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n,
  inout  wire  [15:0]        sram_dq
);

  logic [1:0]         state_q, state_d;
  logic               req;
  logic               tc;
  logic               op_wr_q;
  logic [31:0]        addr_q, wdata_q, rdata_q;
  logic [31:0]        mapped;
  logic [SRAM_AW-2:0] word;
  logic [SRAM_AW-1:0] lo_addr, hi_addr, sram_addr_q;
  logic               unused_mapped;

  assign req     = bus.rd_en | bus.wr_en;
  // Subtraction wraps mod 2^32, so addresses below BASE_ADDR alias high SRAM words.
  assign mapped  = addr_q - BASE_ADDR;
  assign word    = mapped[SRAM_AW:2];
  assign lo_addr = {word, 1'b0};
  assign hi_addr = {word, 1'b1};
  assign unused_mapped = ^{mapped[31:SRAM_AW+1], mapped[1:0]};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = LO;
      LO:      if (tc) state_d = HI;
      HI:      if (tc) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  mem_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk (clk),
    .rst (rst),
    .clr (state_d != state_q),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        addr_q  <= bus.address;
        wdata_q <= bus.write_data;
        op_wr_q <= bus.wr_en;
      end
      if (state_q == LO) sram_addr_q <= lo_addr;
      if (state_q == HI) sram_addr_q <= hi_addr;
      // Sample DQ on the last cycle of each access, when the async SRAM output is stable.
      if (!op_wr_q && tc) begin
        if (state_q == LO) rdata_q[15:0]  <= sram_dq_in;
        if (state_q == HI) rdata_q[31:16] <= sram_dq_in;
      end
    end
  end

  always_comb begin
    sram_addr   = sram_addr_q;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = '0;
    if (state_q == LO) begin
      sram_addr = lo_addr;
      if (op_wr_q) begin
        sram_we_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_dq_out = wdata_q[15:0];
      end
    end else if (state_q == HI) begin
      sram_addr = hi_addr;
      if (op_wr_q) begin
        sram_we_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_dq_out = wdata_q[31:16];
      end
    end
  end

  assign bus.ready     = ((state_q == IDLE) && !req) || (state_q == DONE);
  assign bus.read_data = rdata_q;
  assign sram_dq       = sram_dq_oe ? sram_dq_out : 16'bz;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: directed and random loads/stores checked cycle by cycle
// against a transaction-level model of timing, address mapping and memory contents.
module tb_mem_sram_ctrl;

  localparam int unsigned W    = 2;
  localparam int unsigned BASE = 1024;
  localparam int unsigned AW   = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_sram_ctrl_if bus ();
  mem_sram_ctrl_if bus1 ();

  logic [AW-1:0] sram_addr, sram_addr1;
  logic [15:0]   dq_out, dq_out1, dq_in, dq_in1;
  logic          oe, oe1, we_n, we_n1;
  wire  [15:0]   sram_dq, sram_dq1;

  mem_sram_ctrl #(
    .WAIT_CYCLES (W),
    .BASE_ADDR   (BASE),
    .SRAM_AW     (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .sram_addr   (sram_addr),
    .sram_dq_out (dq_out),
    .sram_dq_oe  (oe),
    .sram_dq_in  (dq_in),
    .sram_we_n   (we_n),
    .sram_dq     (sram_dq)
  );

  mem_sram_ctrl #(
    .WAIT_CYCLES (1),
    .BASE_ADDR   (BASE),
    .SRAM_AW     (AW)
  ) dut1 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus1),
    .sram_addr   (sram_addr1),
    .sram_dq_out (dq_out1),
    .sram_dq_oe  (oe1),
    .sram_dq_in  (dq_in1),
    .sram_we_n   (we_n1),
    .sram_dq     (sram_dq1)
  );

  always #5 clk = ~clk;

  // Second instance sees a fixed, address-derived SRAM image.
  assign dq_in1 = sram_addr1[15:0] ^ 16'hC3A5;

  logic [15:0] sram_mem [int];
  logic [15:0] ref_mem  [int];
  logic [31:0] exp_rd;
  int          n_err;
  int          n_chk;

  function automatic logic [15:0] dflt(input int a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  function automatic logic [15:0] sram_rd(input int a);
    return sram_mem.exists(a) ? sram_mem[a] : dflt(a);
  endfunction

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Behaves as the SRAM: present data for the current address, latch writes.
  task automatic settle();
    #1;
    dq_in = sram_rd(int'(sram_addr));
    if (!we_n) sram_mem[int'(sram_addr)] = dq_out;
  endtask

  task automatic idle_step();
    next_cycle();
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    settle();
    chk("idle_ready", 32'(bus.ready), 32'd1);
    chk("idle_we_n", 32'(we_n), 32'd1);
    chk("idle_oe", 32'(oe), 32'd0);
    chk("idle_rdata", bus.read_data, exp_rd);
  endtask

  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd);
    logic [31:0] m;
    int          lo;
    int          ha;
    logic [15:0] wh;
    m  = a - BASE;
    lo = int'((m >> 2) & 32'h1FFFF) * 2;
    next_cycle();
    bus.rd_en      = rd;
    bus.wr_en      = wr;
    bus.address    = a;
    bus.write_data = wd;
    settle();
    chk("req_ready", 32'(bus.ready), 32'd0);
    chk("req_rdata", bus.read_data, exp_rd);
    for (int c = 1; c <= 2 * W; c++) begin
      ha = (c <= W) ? lo : lo + 1;
      wh = (c <= W) ? wd[15:0] : wd[31:16];
      next_cycle();
      settle();
      chk("busy_ready", 32'(bus.ready), 32'd0);
      chk("busy_addr", 32'(sram_addr), 32'(ha));
      chk("busy_we_n", 32'(we_n), wr ? 32'd0 : 32'd1);
      chk("busy_oe", 32'(oe), wr ? 32'd1 : 32'd0);
      chk("busy_dq", 32'(dq_out), wr ? 32'(wh) : 32'd0);
      if (wr) chk("pad_dq", 32'(sram_dq), 32'(wh));
    end
    if (wr) begin
      ref_mem[lo]     = wd[15:0];
      ref_mem[lo + 1] = wd[31:16];
    end else begin
      exp_rd = {ref_rd(lo + 1), ref_rd(lo)};
    end
    next_cycle();
    settle();
    chk("done_ready", 32'(bus.ready), 32'd1);
    chk("done_rdata", bus.read_data, exp_rd);
    chk("done_we_n", 32'(we_n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    int          kind;
    n_err = 0;
    n_chk = 0;
    exp_rd = '0;
    dq_in = '0;
    bus.rd_en = 1'b1;
    bus.wr_en = 1'b0;
    bus.address = 32'd1032;
    bus.write_data = '0;
    bus1.rd_en = 1'b0;
    bus1.wr_en = 1'b0;
    bus1.address = '0;
    bus1.write_data = '0;

    // Reset held two cycles with a pending load.
    next_cycle();
    next_cycle();
    rst = 1'b0;
    bus.rd_en = 1'b0;
    settle();
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_we_n", 32'(we_n), 32'd1);
    chk("rst_oe", 32'(oe), 32'd0);
    chk("rst_rdata", bus.read_data, 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);

    run_txn(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF);
    idle_step();
    run_txn(1'b1, 1'b0, 32'd1032, 32'h0);
    chk("load_deadbeef", bus.read_data, 32'hDEAD_BEEF);
    // Back-to-back: load then store with no idle gap.
    run_txn(1'b1, 1'b0, 32'd1032, 32'h0);
    run_txn(1'b0, 1'b1, 32'd1036, 32'h1234_5678);
    run_txn(1'b1, 1'b1, 32'd1040, 32'hA5A5_0F0F);
    run_txn(1'b1, 1'b0, 32'd1040, 32'h0);
    run_txn(1'b1, 1'b0, 32'd4, 32'h0);

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 1023);
      else a = BASE + ($urandom_range(0, 7) * 4) + $urandom_range(0, 3);
      wd = $urandom;
      run_txn(kind != 1, kind != 0, a, wd);
      if ($urandom_range(0, 1) == 1) idle_step();
    end

    // Reset during the HI phase of a load aborts it.
    next_cycle();
    bus.rd_en = 1'b1;
    bus.wr_en = 1'b0;
    bus.address = 32'd1032;
    settle();
    for (int c = 1; c < W + 1; c++) begin
      next_cycle();
      settle();
    end
    next_cycle();
    rst = 1'b1;
    bus.rd_en = 1'b0;
    settle();
    next_cycle();
    rst = 1'b0;
    settle();
    exp_rd = '0;
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_rdata", bus.read_data, 32'd0);
    chk("abort_we_n", 32'(we_n), 32'd1);
    chk("abort_addr", 32'(sram_addr), 32'd0);

    // Single-cycle accesses: ready rises three cycles after the request.
    next_cycle();
    bus1.rd_en = 1'b1;
    bus1.address = 32'd1036;
    #1;
    chk("w1_c0_ready", 32'(bus1.ready), 32'd0);
    next_cycle();
    chk("w1_c1_ready", 32'(bus1.ready), 32'd0);
    chk("w1_c1_addr", 32'(sram_addr1), 32'd6);
    next_cycle();
    chk("w1_c2_ready", 32'(bus1.ready), 32'd0);
    chk("w1_c2_addr", 32'(sram_addr1), 32'd7);
    next_cycle();
    chk("w1_c3_ready", 32'(bus1.ready), 32'd1);
    chk("w1_c3_rdata", bus1.read_data, {16'h0007 ^ 16'hC3A5, 16'h0006 ^ 16'hC3A5});
    bus1.rd_en = 1'b0;
    next_cycle();
    chk("w1_idle_ready", 32'(bus1.ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
